// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared types and constants for the rv32i front end.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- what decode sees when the queue is empty
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_mem.sv
// ============================================================================
// Module      : fq_mem
// Description : DEPTH x WIDTH flop storage, synchronous write, async read.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fq_mem #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Storage is intentionally left unreset; occupancy alone qualifies reads.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : FWFT prefetch FIFO of {pc, instr} between fetch and decode.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              w_push, w_pop;
  logic [2*XLEN-1:0] w_rdata;

  // Handshake status depends only on registered occupancy.
  assign in_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != '0);

  assign w_push = in_valid  & in_ready  & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
      else if (w_pop && !w_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fq_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (2*XLEN),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (wr_ptr_q),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr_q),
    .rdata (w_rdata)
  );

  // An empty queue presents a NOP at pc 0 so decode never sees stale storage.
  assign out_pc    = out_valid ? w_rdata[2*XLEN-1:XLEN] : '0;
  assign out_instr = out_valid ? w_rdata[XLEN-1:0]      : XLEN'(NOP_INSTR);
  assign count     = count_q;

endmodule

`default_nettype wire
